// File: rtl/radix4_mac.sv
// Sequential radix-4 multiply-accumulate: P = A*B + C on 8-bit unsigned operands.
// Retires one 2-bit multiplier digit per cycle, MSB first, then adds the addend.
module radix4_mac (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_c;
    logic [15:0] r_acc;
    logic [1:0]  r_count;
    logic [15:0] r_p;
    logic [9:0]  w_mult;
    logic [15:0] w_acc_shift;
    logic [15:0] w_acc_add;

    // Multiple of the multiplicand selected by one radix-4 digit; 3*255 fits in 10 bits.
    function automatic logic [9:0] digit_multiple(input logic [1:0] d, input logic [7:0] a);
        logic [9:0] a10;
        a10 = {2'b00, a};
        case (d)
            2'd0:    digit_multiple = 10'd0;
            2'd1:    digit_multiple = a10;
            2'd2:    digit_multiple = a10 << 1;
            default: digit_multiple = (a10 << 1) + a10;
        endcase
    endfunction

    assign w_mult      = digit_multiple(r_b[7:6], r_a);
    assign w_acc_shift = {r_acc[13:0], 2'b00} + {6'b000000, w_mult};
    assign w_acc_add   = r_acc + {8'h00, r_c};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_count == 2'd3) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                // A held enable must be seen low before another start is accepted.
                if (!enable) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_c     <= 8'h00;
            r_acc   <= 16'h0000;
            r_count <= 2'd0;
            r_p     <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= C;
                        r_acc   <= 16'h0000;
                        r_count <= 2'd0;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_shift;
                    r_b     <= {r_b[5:0], 2'b00};
                    r_count <= r_count + 2'd1;
                end
                S_ADD: begin
                    // Result cannot exceed 0xFF00, so no carry-out is kept.
                    r_acc <= w_acc_add;
                    r_p   <= w_acc_add;
                end
                default: begin
                end
            endcase
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_radix4_mac.sv
// Scoreboard bench for radix4_mac: directed operands with hand-computed A*B+C,
// monitor checks P and 5-cycle latency whenever done rises.
module tb_radix4_mac;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  C;
    logic [15:0] P;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] p;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        done_q = 1'b0;
    logic [15:0] last_p = 16'h0000;

    radix4_mac dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .A      (A),
        .B      (B),
        .C      (C),
        .P      (P),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expected result per rising edge of done.
    always @(negedge clk) begin
        exp_t e;
        if (busy && done) begin
            check("busy_done_exclusive", 32'd1, 32'd0);
        end
        if (resetn && done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result_P", {16'h0, P}, {16'h0, e.p});
                check("result_latency", cyc, e.cyc);
            end
        end
        done_q <= done;
    end

    // mode 0: normal, 1: scramble operands while busy, 2: hold enable across DONE.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [15:0] exp_p, input int mode, input string name);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        @(negedge clk);
        A = a; B = b; C = c; enable = 1'b1;
        @(posedge clk);
        #1;
        e.p   = exp_p;
        e.cyc = cyc + 5;
        sb.push_back(e);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mode != 2) enable = 1'b0;
            if (mode == 1) begin
                A = 8'($urandom); B = 8'($urandom); C = 8'($urandom);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) begin
                busy_cnt++;
                check({name, "_P_stable_while_busy"}, {16'h0, P}, {16'h0, last_p});
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_back());
        end
        check({name, "_busy_cycles"}, busy_cnt, 5);
        last_p = exp_p;
        if (mode == 2) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check({name, "_hold_done"}, {31'h0, done}, 32'd1);
                check({name, "_hold_P"}, {16'h0, P}, {16'h0, exp_p});
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; A = 8'h00; B = 8'h00; C = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_P", {16'h0, P}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_done", {31'h0, done}, 32'd0);
        resetn = 1'b1;

        run(8'd3,   8'd5,   8'd1,   16'h0010, 0, "basic");
        run(8'd7,   8'd14,  8'd2,   16'h0064, 0, "div_7_14_2");
        run(8'd9,   8'd22,  8'd2,   16'h00C8, 0, "div_9_22_2");
        run(8'd16,  8'd15,  8'd15,  16'h00FF, 0, "div_16_15_15");
        run(8'hFF,  8'hFF,  8'hFF,  16'hFF00, 0, "max");
        run(8'h00,  8'hC8,  8'h00,  16'h0000, 0, "zero_a");
        run(8'h80,  8'h02,  8'h00,  16'h0100, 0, "a80_b02");
        run(8'h12,  8'h34,  8'h56,  16'h03FE, 0, "mixed1");
        run(8'hAB,  8'hCD,  8'hEF,  16'h89DE, 0, "mixed2");
        run(8'h10,  8'h10,  8'h05,  16'h0105, 2, "hold");
        run(8'h0F,  8'h11,  8'h00,  16'h00FF, 0, "restart");
        run(8'h55,  8'h66,  8'h77,  16'h2255, 1, "scramble");

        // Abort mid-calculation with reset, then confirm a clean restart.
        @(negedge clk);
        A = 8'hFF; B = 8'hFF; C = 8'h00; enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midreset_P", {16'h0, P}, 32'h0);
        check("midreset_busy", {31'h0, busy}, 32'd0);
        check("midreset_done", {31'h0, done}, 32'd0);
        resetn = 1'b1;
        last_p = 16'h0000;
        run(8'd2, 8'd3, 8'd0, 16'h0006, 0, "after_reset");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
